tcm_port_arbiter: RTL and testbench
===================================

# tcm_port_arbiter

Arbitrates a single-port, 1-cycle-latency TCM RAM between two requesters: the CPU data port (port 0) and the loader/debug port (port 1). The loader port is the path used to preload program images and to inspect memory at run time. The block sits between the core's LSU, the loader master and the TCM macro. It owns conflict resolution, starvation protection and response routing.

## Interface
- `ADDR_W`, 15: word-address width (128 KB TCM).
- `PRIO_CPU`, 1: 1 = CPU-priority with starvation guard; 0 = round-robin.
- `STARVE_LIMIT`, 8: consecutive losing cycles before the loader is forced through (1..255).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1: request valid.
- `p0_we`, `p1_we` in 1: 1 = write.
- `p0_addr`, `p1_addr` in ADDR_W: word address.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_be`, `p1_be` in 4: byte enables.
- `p0_gnt`, `p1_gnt` out 1: request accepted this cycle (combinational).
- `p0_ack`, `p1_ack` out 1: response, 1 cycle after grant.
- `p0_rdata`, `p1_rdata` out 32: read data, valid with ack on reads.
- `ram_en`, `ram_we` out 1: RAM enable and write enable.
- `ram_be` out 4: RAM byte enables.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, registered 1 cycle after `ram_en`.
- `perf_p0_gnt`, `perf_p1_gnt`, `perf_conflict` out 32: performance counters.

## Operation
- Handshake:
  - A request holds `req`/`we`/`addr`/`wdata`/`be` stable until `gnt`.
  - `gnt` is combinational from `req` and state.
  - At most one `gnt` per cycle. Back-to-back grants to the same port are allowed.
- Arbitration:
  - Single requester: it is granted immediately.
  - Conflict (both req):
    - PRIO_CPU=1: port 0 wins unless `starve_cnt == STARVE_LIMIT`, in which case port 1 wins.
    - PRIO_CPU=0: the port opposite `last_gnt` wins.
- `starve_cnt` (8-bit):
  - Increments when p1_req && !p1_gnt.
  - Clears on p1_gnt or !p1_req.
  - Saturates at STARVE_LIMIT.
- `last_gnt` updates to the granted port id on every grant.
- RAM side: `ram_en` = p0_gnt | p1_gnt. The `ram_*` fields are muxed from the granted port. `ram_we` = granted `we`.
- Response: the registered `rsp_vld`/`rsp_port` drive the ack of that port next cycle, for both reads and writes. `rdata` = `ram_rdata` for the acked port, 0 otherwise.
- Same-address write then read on consecutive cycles returns the new data (RAM write-first assumed of macro; no forwarding in this block).

## Timing
- Grant latency: 0 cycles uncontended; at most STARVE_LIMIT+1 cycles for port 1 under continuous port-0 load.
- Ack/rdata: exactly 1 cycle after grant. Throughput: 1 access/cycle.
- Reset values: `gnt`=0 (with no req), `ack`=0, `rdata`=0, `ram_en`=0, `starve_cnt`=0, `last_gnt`=1 (port 0 wins first RR conflict), all perf counters 0.
- Reset asserted mid-access: any pending ack is dropped; no ack is issued after reset deassertion.
- Perf counters wrap at 2^32 silently.

## Configuration
- `TCM_ARB_PERF_EN` defined: `perf_p0_gnt`/`perf_p1_gnt` count grants per port; `perf_conflict` counts cycles with both req high.
- Undefined: counters are not built and the perf outputs are tied to 0.

## Structure
- Shared package `riscv_tcm_pkg`: port id constants (`TCM_PORT_CPU`=0, `TCM_PORT_LDR`=1), data width 32, BE width 4.
- One sub-module `tcm_arb_pick`: pure grant logic (reqs, last_gnt, starve_hit → gnt vector). The top level holds the registers, muxes and counters.

## Test plan
- Reset with both req=1 → no `ram_en` during reset. First cycle after release: p0_gnt=1 (PRIO_CPU=1).
- Port 1 alone writes 0xDEADBEEF to 0x0100 (be=0xF), then reads 0x0100 → p1_ack 1 cycle after each grant; p1_rdata=0xDEADBEEF; p0_ack stays 0.
- Both request continuously, PRIO_CPU=1, STARVE_LIMIT=8 → pattern is 8 p0 grants, 1 p1 grant, repeating. `starve_cnt` returns to 0 after the p1 grant.
- PRIO_CPU=0, both request continuously for 10 cycles → grants alternate p0,p1,…; 5 grants each.
- Byte write be=0x2 of 0x0000AB00 to a word holding 0x11223344 → read returns 0x1122AB44.
- rst_n pulsed low the cycle after a p0 read grant → p0_ack never asserts. With TCM_ARB_PERF_EN, counters read 0 after release.

Source files
------------

// File: rtl/tcm_port_arbiter_pkg.sv
// Shared TCM definitions used by the port arbiter: requester port ids and
// the fixed data / byte-enable widths of the TCM macro.
package riscv_tcm_pkg;

    localparam int TCM_DATA_W = 32;
    localparam int TCM_BE_W   = 4;

    typedef enum logic {
        TCM_PORT_CPU = 1'b0,
        TCM_PORT_LDR = 1'b1
    } tcm_port_e;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// One TCM requester port: request fields from the master, grant/ack/read
// data back from the arbiter.
interface tcm_port_arbiter_if
    import riscv_tcm_pkg::*;
#(
    parameter int ADDR_W = 15
);

    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [TCM_DATA_W-1:0] wdata;
    logic [TCM_BE_W-1:0]   be;
    logic                  gnt;
    logic                  ack;
    logic [TCM_DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, ack, rdata);

endinterface

// File: rtl/tcm_port_arbiter_pick.sv
// Pure grant selection for the two TCM ports; holds no state.
module tcm_arb_pick
    import riscv_tcm_pkg::*;
#(
    parameter int PRIO_CPU = 1
) (
    input  logic [1:0] i_req,
    input  tcm_port_e  i_last_gnt,
    input  logic       i_starve_hit,
    output logic [1:0] o_gnt
);

    // A lone requester always wins; only a conflict needs a policy.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            if (PRIO_CPU != 0) begin
                o_gnt = i_starve_hit ? 2'b10 : 2'b01;
            end else begin
                o_gnt = (i_last_gnt == TCM_PORT_LDR) ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency TCM RAM.
// Define TCM_ARB_PERF_EN to build the grant/conflict performance counters.
module tcm_port_arbiter
    import riscv_tcm_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int PRIO_CPU     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tcm_port_arbiter_if.slave     p0,
    tcm_port_arbiter_if.slave     p1,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [TCM_BE_W-1:0]   ram_be,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [TCM_DATA_W-1:0] ram_wdata,
    input  logic [TCM_DATA_W-1:0] ram_rdata,
    output logic [31:0]           perf_p0_gnt,
    output logic [31:0]           perf_p1_gnt,
    output logic [31:0]           perf_conflict
);

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;
    logic       w_starve_hit;
    logic [7:0] r_starve_cnt;
    tcm_port_e  r_last_gnt;
    tcm_port_e  r_rsp_port;
    logic       r_rsp_vld;

    assign w_req        = {p1.req, p0.req};
    assign w_starve_hit = (r_starve_cnt == 8'(STARVE_LIMIT));

    tcm_arb_pick #(
        .PRIO_CPU (PRIO_CPU)
    ) u_pick (
        .i_req        (w_req),
        .i_last_gnt   (r_last_gnt),
        .i_starve_hit (w_starve_hit),
        .o_gnt        (w_pick)
    );

    // Grants are suppressed while reset is held so the RAM is never enabled.
    assign w_gnt  = rst_n ? w_pick : 2'b00;
    assign p0.gnt = w_gnt[0];
    assign p1.gnt = w_gnt[1];
    assign ram_en = |w_gnt;

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt[1]) begin
            ram_we    = p1.we;
            ram_be    = p1.be;
            ram_addr  = p1.addr;
            ram_wdata = p1.wdata;
        end else if (w_gnt[0]) begin
            ram_we    = p0.we;
            ram_be    = p0.be;
            ram_addr  = p0.addr;
            ram_wdata = p0.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_last_gnt   <= TCM_PORT_LDR;
            r_rsp_vld    <= 1'b0;
            r_rsp_port   <= TCM_PORT_CPU;
        end else begin
            if (!p1.req || w_gnt[1]) begin
                r_starve_cnt <= '0;
            end else if (!w_starve_hit) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
            if (ram_en) begin
                r_last_gnt <= w_gnt[1] ? TCM_PORT_LDR : TCM_PORT_CPU;
            end
            r_rsp_vld  <= ram_en;
            r_rsp_port <= w_gnt[1] ? TCM_PORT_LDR : TCM_PORT_CPU;
        end
    end

    assign p0.ack   = r_rsp_vld && (r_rsp_port == TCM_PORT_CPU);
    assign p1.ack   = r_rsp_vld && (r_rsp_port == TCM_PORT_LDR);
    assign p0.rdata = p0.ack ? ram_rdata : '0;
    assign p1.rdata = p1.ack ? ram_rdata : '0;

`ifdef TCM_ARB_PERF_EN
    logic [31:0] r_perf_p0;
    logic [31:0] r_perf_p1;
    logic [31:0] r_perf_conflict;

    // Free-running counters; wrapping at 2^32 is intentional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_p0       <= '0;
            r_perf_p1       <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_gnt[0]) r_perf_p0 <= r_perf_p0 + 32'd1;
            if (w_gnt[1]) r_perf_p1 <= r_perf_p1 + 32'd1;
            if (&w_req)   r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_p0_gnt   = r_perf_p0;
    assign perf_p1_gnt   = r_perf_p1;
    assign perf_conflict = r_perf_conflict;
`else
    assign perf_p0_gnt   = '0;
    assign perf_p1_gnt   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: a CPU-priority instance (limit 8) and a
// round-robin instance share the same directed stimulus and a cycle model.
module tb_tcm_port_arbiter;
    import riscv_tcm_pkg::*;

    localparam int AW    = 15;
    localparam int LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tcm_port_arbiter_if #(.ADDR_W(AW)) p0A ();
    tcm_port_arbiter_if #(.ADDR_W(AW)) p1A ();
    tcm_port_arbiter_if #(.ADDR_W(AW)) p0B ();
    tcm_port_arbiter_if #(.ADDR_W(AW)) p1B ();

    logic          ramEnA, ramWeA, ramEnB, ramWeB;
    logic [3:0]    ramBeA, ramBeB;
    logic [AW-1:0] ramAddrA, ramAddrB;
    logic [31:0]   ramWdataA, ramWdataB;
    logic [31:0]   ramRdataA = '0;
    logic [31:0]   ramRdataB = '0;
    logic [31:0]   perfP0A, perfP1A, perfConfA, perfP0B, perfP1B, perfConfB;

    tcm_port_arbiter #(.ADDR_W(AW), .PRIO_CPU(1), .STARVE_LIMIT(LIMIT)) dutPrio (
        .clk(clk), .rst_n(rst_n), .p0(p0A), .p1(p1A),
        .ram_en(ramEnA), .ram_we(ramWeA), .ram_be(ramBeA), .ram_addr(ramAddrA),
        .ram_wdata(ramWdataA), .ram_rdata(ramRdataA),
        .perf_p0_gnt(perfP0A), .perf_p1_gnt(perfP1A), .perf_conflict(perfConfA)
    );

    tcm_port_arbiter #(.ADDR_W(AW), .PRIO_CPU(0), .STARVE_LIMIT(LIMIT)) dutRr (
        .clk(clk), .rst_n(rst_n), .p0(p0B), .p1(p1B),
        .ram_en(ramEnB), .ram_we(ramWeB), .ram_be(ramBeB), .ram_addr(ramAddrB),
        .ram_wdata(ramWdataB), .ram_rdata(ramRdataB),
        .perf_p0_gnt(perfP0B), .perf_p1_gnt(perfP1B), .perf_conflict(perfConfB)
    );

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
        return r;
    endfunction

    // Write-first RAM macros with 1-cycle read latency.
    logic [31:0] memA [int];
    logic [31:0] memB [int];

    always @(posedge clk) begin
        if (ramEnA) begin
            logic [31:0] cur;
            cur = memA.exists(int'(ramAddrA)) ? memA[int'(ramAddrA)] : 32'h0;
            if (ramWeA) cur = mergeBytes(cur, ramWdataA, ramBeA);
            memA[int'(ramAddrA)] = cur;
            ramRdataA <= cur;
        end
        if (ramEnB) begin
            logic [31:0] curB;
            curB = memB.exists(int'(ramAddrB)) ? memB[int'(ramAddrB)] : 32'h0;
            if (ramWeB) curB = mergeBytes(curB, ramWdataB, ramBeB);
            memB[int'(ramAddrB)] = curB;
            ramRdataB <= curB;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic we0, input logic [AW-1:0] a0,
                                 input logic [31:0] d0, input logic [3:0] be0,
                                 input logic r1, input logic we1, input logic [AW-1:0] a1,
                                 input logic [31:0] d1, input logic [3:0] be1);
        @(posedge clk);
        #1;
        p0A.req = r0; p0A.we = we0; p0A.addr = a0; p0A.wdata = d0; p0A.be = be0;
        p1A.req = r1; p1A.we = we1; p1A.addr = a1; p1A.wdata = d1; p1A.be = be1;
        p0B.req = r0; p0B.we = we0; p0B.addr = a0; p0B.wdata = d0; p0B.be = be0;
        p1B.req = r1; p1B.we = we1; p1B.addr = a1; p1B.wdata = d1; p1B.be = be1;
    endtask

    // Behavioural model: who must win, what must be acked, what data comes back.
    int          mdlWait = 0;
    int          mdlLastB = 1;
    logic        mdlAckVldA = 1'b0;
    int          mdlAckPortA = 0;
    logic [31:0] mdlAckDataA = '0;
    logic        mdlAckVldB = 1'b0;
    int          mdlAckPortB = 0;
    logic [31:0] mdlMem [int];
    logic [31:0] mdlPerf0 = '0, mdlPerf1 = '0, mdlConf = '0;

    always @(negedge clk) begin
        logic r0, r1, eg0, eg1, bg0, bg1, expAck0, expAck1;
        int k;
        logic [31:0] v;
        r0 = p0A.req;
        r1 = p1A.req;
        if (!rst_n) begin
            checkOutput("rstGnt0", p0A.gnt, 0);
            checkOutput("rstGnt1", p1A.gnt, 0);
            checkOutput("rstRamEn", ramEnA, 0);
            checkOutput("rstRamEnRr", ramEnB, 0);
            checkOutput("rstAck0", p0A.ack, 0);
            checkOutput("rstAck1", p1A.ack, 0);
            checkOutput("rstRdata0", p0A.rdata, 0);
            checkOutput("rstRdata1", p1A.rdata, 0);
            checkOutput("rstPerf", perfP0A | perfP1A | perfConfA, 0);
            checkOutput("rstPerfRr", perfP0B | perfP1B | perfConfB, 0);
            mdlWait = 0; mdlLastB = 1; mdlAckVldA = 0; mdlAckVldB = 0;
            mdlPerf0 = 0; mdlPerf1 = 0; mdlConf = 0;
        end else begin
            eg1 = r1 && (!r0 || mdlWait >= LIMIT);
            eg0 = r0 && !eg1;
            checkOutput("gnt0", p0A.gnt, eg0);
            checkOutput("gnt1", p1A.gnt, eg1);
            checkOutput("ramEn", ramEnA, eg0 | eg1);
            if (eg0 | eg1) begin
                checkOutput("ramWe", ramWeA, eg1 ? p1A.we : p0A.we);
                checkOutput("ramAddr", 32'(ramAddrA), 32'(eg1 ? p1A.addr : p0A.addr));
                checkOutput("ramBe", 32'(ramBeA), 32'(eg1 ? p1A.be : p0A.be));
                if (eg1 ? p1A.we : p0A.we)
                    checkOutput("ramWdata", ramWdataA, eg1 ? p1A.wdata : p0A.wdata);
            end
            expAck0 = mdlAckVldA && mdlAckPortA == 0;
            expAck1 = mdlAckVldA && mdlAckPortA == 1;
            checkOutput("ack0", p0A.ack, expAck0);
            checkOutput("ack1", p1A.ack, expAck1);
            checkOutput("rdata0", p0A.rdata, expAck0 ? mdlAckDataA : 32'h0);
            checkOutput("rdata1", p1A.rdata, expAck1 ? mdlAckDataA : 32'h0);
`ifdef TCM_ARB_PERF_EN
            checkOutput("perfP0", perfP0A, mdlPerf0);
            checkOutput("perfP1", perfP1A, mdlPerf1);
            checkOutput("perfConf", perfConfA, mdlConf);
`else
            checkOutput("perfTied", perfP0A | perfP1A | perfConfA, 0);
`endif
            bg1 = r1 && (!r0 || mdlLastB == 0);
            bg0 = r0 && !bg1;
            checkOutput("rrGnt0", p0B.gnt, bg0);
            checkOutput("rrGnt1", p1B.gnt, bg1);
            checkOutput("rrAck0", p0B.ack, mdlAckVldB && mdlAckPortB == 0);
            checkOutput("rrAck1", p1B.ack, mdlAckVldB && mdlAckPortB == 1);

            mdlWait = (r1 && !eg1) ? ((mdlWait < LIMIT) ? mdlWait + 1 : mdlWait) : 0;
            mdlAckVldA = eg0 | eg1;
            mdlAckPortA = eg1 ? 1 : 0;
            if (eg0 | eg1) begin
                k = eg1 ? int'(p1A.addr) : int'(p0A.addr);
                v = mdlMem.exists(k) ? mdlMem[k] : 32'h0;
                if (eg1 ? p1A.we : p0A.we)
                    v = mergeBytes(v, eg1 ? p1A.wdata : p0A.wdata, eg1 ? p1A.be : p0A.be);
                mdlMem[k] = v;
                mdlAckDataA = v;
            end
            if (eg0) mdlPerf0 = mdlPerf0 + 1;
            if (eg1) mdlPerf1 = mdlPerf1 + 1;
            if (r0 && r1) mdlConf = mdlConf + 1;
            mdlAckVldB = bg0 | bg1;
            mdlAckPortB = bg1 ? 1 : 0;
            if (bg0) mdlLastB = 0;
            if (bg1) mdlLastB = 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0Cnt, p1Cnt, firstP1, rrP0, rrP1;
        logic rrFirst;
        p0A.req = 1; p0A.we = 0; p0A.addr = 15'h0010; p0A.wdata = 0; p0A.be = 4'hF;
        p1A.req = 1; p1A.we = 0; p1A.addr = 15'h0020; p1A.wdata = 0; p1A.be = 4'hF;
        p0B.req = 1; p0B.we = 0; p0B.addr = 15'h0010; p0B.wdata = 0; p0B.be = 4'hF;
        p1B.req = 1; p1B.we = 0; p1B.addr = 15'h0020; p1B.wdata = 0; p1B.be = 4'hF;

        // Reset with both ports requesting, then release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetNoRamEn", ramEnA, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("firstGntP0", p0A.gnt, 1);
        checkOutput("firstGntP1", p1A.gnt, 0);

        // Loader alone: write then read back.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 15'h0100, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        checkOutput("ldrWrGnt", p1A.gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 15'h0100, 0, 4'hF);
        @(negedge clk);
        checkOutput("ldrWrAck", p1A.ack, 1);
        checkOutput("ldrWrNoCpuAck", p0A.ack, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ldrRdAck", p1A.ack, 1);
        checkOutput("ldrRdData", p1A.rdata, 32'hDEADBEEF);
        checkOutput("ldrRdNoCpuAck", p0A.ack, 0);

        // Continuous conflict: starvation guard pattern and round-robin.
        p0Cnt = 0; p1Cnt = 0; firstP1 = -1; rrP0 = 0; rrP1 = 0; rrFirst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1, 0, 15'h0010, 0, 4'hF, 1, 0, 15'h0020, 0, 4'hF);
            @(negedge clk);
            if (p0A.gnt) p0Cnt++;
            if (p1A.gnt) begin
                p1Cnt++;
                if (firstP1 < 0) firstP1 = i;
            end
            if (i < 10) begin
                if (p0B.gnt) rrP0++;
                if (p1B.gnt) rrP1++;
            end
            if (i == 0) rrFirst = p1B.gnt;
        end
        checkOutput("starveP0Grants", 32'(p0Cnt), 16);
        checkOutput("starveP1Grants", 32'(p1Cnt), 2);
        checkOutput("starveFirstP1", 32'(firstP1), 8);
        checkOutput("rrP0Grants", 32'(rrP0), 5);
        checkOutput("rrP1Grants", 32'(rrP1), 5);
        checkOutput("rrFirstIsP0", rrFirst, 0);

        // Byte-lane write into an existing word.
        applyStimulus(1, 1, 15'h0040, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 15'h0040, 32'h0000AB00, 4'h2, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 15'h0040, 0, 4'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("byteWrAck", p0A.ack, 1);
        checkOutput("byteWrData", p0A.rdata, 32'h1122AB44);

        // Reset right after a read grant: its ack must never appear.
        applyStimulus(1, 0, 15'h0040, 0, 4'hF, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("preRstGnt", p0A.gnt, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        p0A.req = 0; p0B.req = 0;
        @(negedge clk);
        checkOutput("rstDropAck", p0A.ack, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("postRstNoAck", p0A.ack, 0);
        end
        checkOutput("postRstPerfP0", perfP0A, 0);
        checkOutput("postRstPerfConf", perfConfA, 0);

        // A few alternating single requests to exercise back-to-back traffic.
        applyStimulus(1, 0, 15'h0100, 0, 4'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 15'h0040, 0, 4'hF);
        applyStimulus(1, 0, 15'h0040, 0, 4'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
